comparator_2b2b_reg: RTL and testbench

- Registered magnitude comparator for two 2-bit unsigned operands: AB = {A,B} and CD = {C,D}; A and C are the MSBs.
- Produces one-hot greater/equal/less flags one clock after sampling.
- Keeps saturating per-outcome event counters for debug and statistics.
- Comparison core is gate-level (AND/OR/XOR/NOT primitives), feeding output registers; used as a leaf in small datapath/control logic.

---
 rtl/comparator_2b2b_reg_if.sv | 31 +++
 rtl/comparator_2b2b_reg.sv | 129 ++++++++++++
 tb/tb_comparator_2b2b_reg.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/comparator_2b2b_reg_if.sv
// Bus bundle for comparator_2b2b_reg.
//   master : drives the sample (in_valid, A..D) and observes the results.
//   slave  : the comparator itself; consumes the sample, drives the
//            registered flags F1..F3, out_valid and the outcome counters.
// CNT_W must match the CNT_W of the comparator attached to this bundle.
interface comparator_2b2b_reg_if #(
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             A;
  logic             B;
  logic             C;
  logic             D;
  logic             F1;
  logic             F2;
  logic             F3;
  logic             out_valid;
  logic [CNT_W-1:0] cnt_gt;
  logic [CNT_W-1:0] cnt_eq;
  logic [CNT_W-1:0] cnt_lt;

  modport master (
    output in_valid, A, B, C, D,
    input  F1, F2, F3, out_valid, cnt_gt, cnt_eq, cnt_lt
  );

  modport slave (
    input  in_valid, A, B, C, D,
    output F1, F2, F3, out_valid, cnt_gt, cnt_eq, cnt_lt
  );
endinterface

// File: rtl/comparator_2b2b_reg.sv
// Registered magnitude comparator for two 2-bit unsigned operands
// AB = {A,B} and CD = {C,D} (A, C are the MSBs).
//   clk            rising-edge clock
//   rst            synchronous, active-high reset (clears flags, valid, counters)
//   bus.in_valid   A..D are sampled on this edge when high
//   bus.A/B/C/D    operand bits
//   bus.F1/F2/F3   registered AB>CD / AB==CD / AB<CD, one cycle after sampling
//   bus.out_valid  F1..F3 were updated on the last edge
//   bus.cnt_gt/eq/lt saturating counts of valid samples per outcome
// The compare core is built from gate primitives; flags hold between valid
// samples while out_valid drops.
module comparator_2b2b_reg #(
  parameter int unsigned CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  comparator_2b2b_reg_if.slave bus
);

  logic a;
  logic b;
  logic c;
  logic d;

  assign a = bus.A;
  assign b = bus.B;
  assign c = bus.C;
  assign d = bus.D;

  // Gate-level compare core
  logic a_n;
  logic b_n;
  logic c_n;
  logic d_n;
  logic ac_eq;
  logic bd_eq;
  logic msb_gt;
  logic msb_lt;
  logic lsb_gt;
  logic lsb_lt;
  logic gt;
  logic eq;
  logic lt;

  not  u_not_a  (a_n, a);
  not  u_not_b  (b_n, b);
  not  u_not_c  (c_n, c);
  not  u_not_d  (d_n, d);

  xnor u_xnor_ac (ac_eq, a, c);
  xnor u_xnor_bd (bd_eq, b, d);

  and  u_and_msb_gt (msb_gt, a, c_n);
  and  u_and_msb_lt (msb_lt, a_n, c);
  // LSBs only decide when the MSBs tie
  and  u_and_lsb_gt (lsb_gt, ac_eq, b, d_n);
  and  u_and_lsb_lt (lsb_lt, ac_eq, b_n, d);

  or   u_or_gt  (gt, msb_gt, lsb_gt);
  and  u_and_eq (eq, ac_eq, bd_eq);
  or   u_or_lt  (lt, msb_lt, lsb_lt);

  // Output registers and counters
  logic             f1_q, f1_d;
  logic             f2_q, f2_d;
  logic             f3_q, f3_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_gt_q, cnt_gt_d;
  logic [CNT_W-1:0] cnt_eq_q, cnt_eq_d;
  logic [CNT_W-1:0] cnt_lt_q, cnt_lt_d;

  logic gt_sat;
  logic eq_sat;
  logic lt_sat;

  assign gt_sat = (cnt_gt_q == '1);
  assign eq_sat = (cnt_eq_q == '1);
  assign lt_sat = (cnt_lt_q == '1);

  always_comb begin
    f1_d        = f1_q;
    f2_d        = f2_q;
    f3_d        = f3_q;
    out_valid_d = 1'b0;
    cnt_gt_d    = cnt_gt_q;
    cnt_eq_d    = cnt_eq_q;
    cnt_lt_d    = cnt_lt_q;
    // Operands are only looked at under in_valid, so junk on A..D
    // while idle cannot reach any state.
    if (bus.in_valid) begin
      f1_d        = gt;
      f2_d        = eq;
      f3_d        = lt;
      out_valid_d = 1'b1;
      if (gt && !gt_sat) cnt_gt_d = cnt_gt_q + CNT_W'(1);
      if (eq && !eq_sat) cnt_eq_d = cnt_eq_q + CNT_W'(1);
      if (lt && !lt_sat) cnt_lt_d = cnt_lt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f1_q        <= 1'b0;
      f2_q        <= 1'b0;
      f3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_gt_q    <= '0;
      cnt_eq_q    <= '0;
      cnt_lt_q    <= '0;
    end else begin
      f1_q        <= f1_d;
      f2_q        <= f2_d;
      f3_q        <= f3_d;
      out_valid_q <= out_valid_d;
      cnt_gt_q    <= cnt_gt_d;
      cnt_eq_q    <= cnt_eq_d;
      cnt_lt_q    <= cnt_lt_d;
    end
  end

  assign bus.F1        = f1_q;
  assign bus.F2        = f2_q;
  assign bus.F3        = f3_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cnt_gt    = cnt_gt_q;
  assign bus.cnt_eq    = cnt_eq_q;
  assign bus.cnt_lt    = cnt_lt_q;

endmodule

// File: tb/tb_comparator_2b2b_reg.sv
// Testbench for comparator_2b2b_reg: two instances (CNT_W=8 and CNT_W=2)
// share one stimulus stream and are checked against a behavioural model.
module tb_comparator_2b2b_reg;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic a_in, b_in, c_in, d_in;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  comparator_2b2b_reg_if #(.CNT_W(8)) bus8 ();
  comparator_2b2b_reg_if #(.CNT_W(2)) bus2 ();

  assign bus8.in_valid = in_valid;
  assign bus8.A = a_in;
  assign bus8.B = b_in;
  assign bus8.C = c_in;
  assign bus8.D = d_in;
  assign bus2.in_valid = in_valid;
  assign bus2.A = a_in;
  assign bus2.B = b_in;
  assign bus2.C = c_in;
  assign bus2.D = d_in;

  comparator_2b2b_reg #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  comparator_2b2b_reg #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Reference model: index 0 -> 8-bit counters, index 1 -> 2-bit counters.
  // m_flg is {gt,eq,lt}; m_cnt[i] is {gt,eq,lt} counts.
  bit [2:0] m_flg [2];
  bit       m_ov  [2];
  int       m_cnt [2][3];
  int       m_max [2] = '{255, 3};

  task automatic drive_cycle(input bit r, input bit v, input bit a,
                             input bit b, input bit c, input bit d);
    int ab;
    int cd;
    int k;
    rst = r; in_valid = v; a_in = a; b_in = b; c_in = c; d_in = d;
    @(posedge clk);
    ab = 2 * int'(a) + int'(b);
    cd = 2 * int'(c) + int'(d);
    k  = (ab > cd) ? 0 : ((ab == cd) ? 1 : 2);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_flg[i] = 3'b000;
        m_ov[i]  = 1'b0;
        for (int j = 0; j < 3; j++) m_cnt[i][j] = 0;
      end else if (v) begin
        m_flg[i] = 3'b100 >> k;
        m_ov[i]  = 1'b1;
        if (m_cnt[i][k] < m_max[i]) m_cnt[i][k] = m_cnt[i][k] + 1;
      end else begin
        m_ov[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(1, 1, 1, 1, 0, 0);
    drive_cycle(1, 1, 1, 1, 0, 0);
    checks++;
    if ({bus8.F1, bus8.F2, bus8.F3, bus8.out_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=0000", {bus8.F1, bus8.F2, bus8.F3, bus8.out_valid});
    end
    checks++;
    if ({bus8.cnt_gt, bus8.cnt_eq, bus8.cnt_lt} !== 24'h0) begin
      errors++;
      $display("FAIL reset_cnt got=%h want=000000", {bus8.cnt_gt, bus8.cnt_eq, bus8.cnt_lt});
    end
    checks++;
    if ({bus2.F1, bus2.F2, bus2.F3, bus2.out_valid, bus2.cnt_gt, bus2.cnt_eq, bus2.cnt_lt} !== 10'h0) begin
      errors++;
      $display("FAIL reset_dut2 got=%h want=000", {bus2.F1, bus2.F2, bus2.F3, bus2.out_valid, bus2.cnt_gt, bus2.cnt_eq, bus2.cnt_lt});
    end
  endtask

  task automatic test_basic();
    drive_cycle(0, 1, 0, 1, 0, 0);
    checks++;
    if ({bus8.F1, bus8.F2, bus8.F3, bus8.out_valid} !== 4'b1001) begin
      errors++;
      $display("FAIL basic_flags got=%b want=1001", {bus8.F1, bus8.F2, bus8.F3, bus8.out_valid});
    end
    checks++;
    if (bus8.cnt_gt !== 8'd1 || bus8.cnt_eq !== 8'd0 || bus8.cnt_lt !== 8'd0) begin
      errors++;
      $display("FAIL basic_cnt got=%0d/%0d/%0d want=1/0/0", bus8.cnt_gt, bus8.cnt_eq, bus8.cnt_lt);
    end
  endtask

  task automatic test_exhaustive();
    bit [3:0] n4;
    drive_cycle(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 16; n++) begin
      n4 = n[3:0];
      drive_cycle(0, 1, n4[3], n4[2], n4[1], n4[0]);
      checks++;
      if ({bus8.F1, bus8.F2, bus8.F3, bus8.out_valid} !== {m_flg[0], 1'b1}) begin
        errors++;
        $display("FAIL exh_flags n=%0d got=%b want=%b", n, {bus8.F1, bus8.F2, bus8.F3, bus8.out_valid}, {m_flg[0], 1'b1});
      end
    end
    checks++;
    if (bus8.cnt_gt !== 8'd6 || bus8.cnt_eq !== 8'd4 || bus8.cnt_lt !== 8'd6) begin
      errors++;
      $display("FAIL exh_cnt got=%0d/%0d/%0d want=6/4/6", bus8.cnt_gt, bus8.cnt_eq, bus8.cnt_lt);
    end
  endtask

  task automatic test_hold();
    drive_cycle(0, 1, 1, 0, 1, 1);
    checks++;
    if ({bus8.F1, bus8.F2, bus8.F3, bus8.out_valid} !== 4'b0011) begin
      errors++;
      $display("FAIL hold_first got=%b want=0011", {bus8.F1, bus8.F2, bus8.F3, bus8.out_valid});
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, 1, 1, 0, 0);
      checks++;
      if ({bus8.F1, bus8.F2, bus8.F3, bus8.out_valid} !== 4'b0010) begin
        errors++;
        $display("FAIL hold_flags cyc=%0d got=%b want=0010", i, {bus8.F1, bus8.F2, bus8.F3, bus8.out_valid});
      end
      checks++;
      if (bus8.cnt_gt !== 8'(m_cnt[0][0]) || bus8.cnt_eq !== 8'(m_cnt[0][1]) || bus8.cnt_lt !== 8'(m_cnt[0][2])) begin
        errors++;
        $display("FAIL hold_cnt cyc=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", i, bus8.cnt_gt, bus8.cnt_eq, bus8.cnt_lt,
                 m_cnt[0][0], m_cnt[0][1], m_cnt[0][2]);
      end
    end
  endtask

  task automatic test_saturation();
    int want;
    drive_cycle(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      drive_cycle(0, 1, 1, 0, 1, 0);
      want = (i < 3) ? i : 3;
      checks++;
      if (bus2.cnt_eq !== 2'(want) || bus2.cnt_gt !== 2'd0 || bus2.cnt_lt !== 2'd0) begin
        errors++;
        $display("FAIL sat_cnt i=%0d got=%0d/%0d/%0d want=0/%0d/0", i, bus2.cnt_gt, bus2.cnt_eq, bus2.cnt_lt, want);
      end
      checks++;
      if ({bus2.F1, bus2.F2, bus2.F3, bus2.out_valid} !== 4'b0101) begin
        errors++;
        $display("FAIL sat_flags i=%0d got=%b want=0101", i, {bus2.F1, bus2.F2, bus2.F3, bus2.out_valid});
      end
    end
    checks++;
    if (bus8.cnt_eq !== 8'd5) begin
      errors++;
      $display("FAIL sat_wide got=%0d want=5", bus8.cnt_eq);
    end
    // Other counters keep counting independently once eq is pinned
    drive_cycle(0, 1, 1, 1, 0, 0);
    checks++;
    if (bus2.cnt_gt !== 2'd1 || bus2.cnt_eq !== 2'd3) begin
      errors++;
      $display("FAIL sat_indep got=%0d/%0d want=1/3", bus2.cnt_gt, bus2.cnt_eq);
    end
  endtask

  task automatic test_reset_mid();
    drive_cycle(0, 1, 0, 0, 1, 1);
    drive_cycle(1, 1, 1, 1, 0, 1);
    checks++;
    if ({bus8.F1, bus8.F2, bus8.F3, bus8.out_valid} !== 4'b0000 || bus8.cnt_gt !== 8'd0 || bus8.cnt_lt !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid got=%b gt=%0d lt=%0d want=0000 gt=0 lt=0",
               {bus8.F1, bus8.F2, bus8.F3, bus8.out_valid}, bus8.cnt_gt, bus8.cnt_lt);
    end
    drive_cycle(0, 0, 1, 1, 0, 1);
    checks++;
    if ({bus8.F1, bus8.F2, bus8.F3, bus8.out_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_idle got=%b want=0000", {bus8.F1, bus8.F2, bus8.F3, bus8.out_valid});
    end
  endtask

  task automatic test_back_to_back();
    bit r, v;
    bit [3:0] op;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 3) != 0);
      op = 4'($urandom);
      drive_cycle(r, v, op[3], op[2], op[1], op[0]);
      checks++;
      if ({bus8.F1, bus8.F2, bus8.F3, bus8.out_valid} !== {m_flg[0], m_ov[0]} ||
          bus8.cnt_gt !== 8'(m_cnt[0][0]) || bus8.cnt_eq !== 8'(m_cnt[0][1]) || bus8.cnt_lt !== 8'(m_cnt[0][2])) begin
        errors++;
        $display("FAIL rand8 i=%0d got=%b %0d/%0d/%0d want=%b %0d/%0d/%0d", i,
                 {bus8.F1, bus8.F2, bus8.F3, bus8.out_valid}, bus8.cnt_gt, bus8.cnt_eq, bus8.cnt_lt,
                 {m_flg[0], m_ov[0]}, m_cnt[0][0], m_cnt[0][1], m_cnt[0][2]);
      end
      checks++;
      if ({bus2.F1, bus2.F2, bus2.F3, bus2.out_valid} !== {m_flg[1], m_ov[1]} ||
          bus2.cnt_gt !== 2'(m_cnt[1][0]) || bus2.cnt_eq !== 2'(m_cnt[1][1]) || bus2.cnt_lt !== 2'(m_cnt[1][2])) begin
        errors++;
        $display("FAIL rand2 i=%0d got=%b %0d/%0d/%0d want=%b %0d/%0d/%0d", i,
                 {bus2.F1, bus2.F2, bus2.F3, bus2.out_valid}, bus2.cnt_gt, bus2.cnt_eq, bus2.cnt_lt,
                 {m_flg[1], m_ov[1]}, m_cnt[1][0], m_cnt[1][1], m_cnt[1][2]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    a_in = 1'b0; b_in = 1'b0; c_in = 1'b0; d_in = 1'b0;
    test_reset();
    test_basic();
    test_exhaustive();
    test_hold();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
